// File: rtl/seg_scan_ctrl_pkg.sv
// Shared constants, FSM state type and segment encoder for the seven-segment scan controller.
// Segment codes are active-low, bit order {dp,g,f,e,d,c,b,a}.
package seg_pkg;

  localparam int NUM_DIGITS = 8;
  localparam int BIN_W      = 24;
  localparam int BCD_W      = 4 * NUM_DIGITS;
  localparam int HEX_DIGITS = BIN_W / 4;

  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_A     = 8'h88;
  localparam logic [7:0] SEG_B     = 8'h83;
  localparam logic [7:0] SEG_C     = 8'hC6;
  localparam logic [7:0] SEG_D     = 8'hA1;
  localparam logic [7:0] SEG_E     = 8'h86;
  localparam logic [7:0] SEG_F     = 8'h8E;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CONV   = 2'd1,
    COMMIT = 2'd2
  } state_e;

  function automatic logic [7:0] seg_encode(input logic [3:0] d);
    logic [7:0] s;
    case (d)
      4'h0:    s = SEG_0;
      4'h1:    s = SEG_1;
      4'h2:    s = SEG_2;
      4'h3:    s = SEG_3;
      4'h4:    s = SEG_4;
      4'h5:    s = SEG_5;
      4'h6:    s = SEG_6;
      4'h7:    s = SEG_7;
      4'h8:    s = SEG_8;
      4'h9:    s = SEG_9;
      4'hA:    s = SEG_A;
      4'hB:    s = SEG_B;
      4'hC:    s = SEG_C;
      4'hD:    s = SEG_D;
      4'hE:    s = SEG_E;
      default: s = SEG_F;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// CPU-side load port and board-side display pins of the scan controller.
interface seg_scan_ctrl_if;
  import seg_pkg::*;

  // load is a one-cycle strobe; it is accepted only on a cycle where busy=0
  // and silently dropped otherwise (busy acts as the inverted ready).
  logic                  load;
  logic [BIN_W-1:0]      value;
  logic                  dec_mode;
  logic                  blank_lz;
  logic                  busy;
  logic [NUM_DIGITS-1:0] seg_en;
  logic [7:0]            seg_out;
  state_e                dbg_state;

  modport master (
    output load, value, dec_mode, blank_lz,
    input  busy, seg_en, seg_out, dbg_state
  );

  modport slave (
    input  load, value, dec_mode, blank_lz,
    output busy, seg_en, seg_out, dbg_state
  );

endinterface

// File: rtl/seg_scan_ctrl_bin2bcd.sv
// Sequential double-dabble converter: one add-3/shift iteration per cycle after start.
// done_o is high during the cycle that performs the final iteration.
module bin2bcd_seq
  import seg_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [BIN_W-1:0] bin_i,
  output logic             done_o,
  output logic [BCD_W-1:0] bcd_o
);

  localparam int SH_W  = BIN_W + BCD_W;
  localparam int CNT_W = $clog2(BIN_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);

  logic [SH_W-1:0]  sh_q, sh_d, adj;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             run_q, run_d;

  always_comb begin
    adj   = sh_q;
    sh_d  = sh_q;
    cnt_d = cnt_q;
    run_d = run_q;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (sh_q[BIN_W + 4*i +: 4] >= 4'd5) adj[BIN_W + 4*i +: 4] = sh_q[BIN_W + 4*i +: 4] + 4'd3;
    end
    if (start_i) begin
      sh_d  = {{BCD_W{1'b0}}, bin_i};
      cnt_d = '0;
      run_d = 1'b1;
    end else if (run_q) begin
      sh_d  = adj << 1;
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == CNT_LAST) run_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sh_q  <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
    end else begin
      sh_q  <= sh_d;
      cnt_q <= cnt_d;
      run_q <= run_d;
    end
  end

  assign done_o = run_q && (cnt_q == CNT_LAST);
  assign bcd_o  = sh_q[SH_W-1 -: BCD_W];

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed 8-digit seven-segment driver: load FSM, double-buffered digits, prescaled scan.
// The buffer only changes on a hex load or at COMMIT, so a conversion is never shown half done.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int CLK_HZ     = 100000000,
  parameter int REFRESH_HZ = 1000
) (
  input  logic           clk,
  input  logic           rst_n,
  seg_scan_ctrl_if.slave bus
);

  localparam int SCAN_DIV = CLK_HZ / (REFRESH_HZ * NUM_DIGITS);
  localparam int PRE_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W    = $clog2(NUM_DIGITS);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);

  state_e                     state_q, state_d;
  logic                       lat_blz_q, lat_blz_d;
  logic [NUM_DIGITS-1:0][3:0] digits_q, digits_d;
  logic                       buf_dec_q, buf_dec_d;
  logic                       buf_blz_q, buf_blz_d;
  logic [PRE_W-1:0]           pre_q, pre_d;
  logic [IDX_W-1:0]           idx_q, idx_d;
  logic [NUM_DIGITS-1:0]      seg_en_q, seg_en_d;
  logic [7:0]                 seg_out_q, seg_out_d;

  logic             start;
  logic             done;
  logic [BCD_W-1:0] bcd;
  logic [BCD_W-1:0] above;
  logic             blank;

  bin2bcd_seq u_conv (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (start),
    .bin_i   (bus.value),
    .done_o  (done),
    .bcd_o   (bcd)
  );

  always_comb begin
    state_d   = state_q;
    lat_blz_d = lat_blz_q;
    digits_d  = digits_q;
    buf_dec_d = buf_dec_q;
    buf_blz_d = buf_blz_q;
    start     = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.load) begin
          if (bus.dec_mode) begin
            state_d   = CONV;
            start     = 1'b1;
            lat_blz_d = bus.blank_lz;
          end else begin
            digits_d  = BCD_W'(bus.value);
            buf_dec_d = 1'b0;
            buf_blz_d = bus.blank_lz;
          end
        end
      end
      CONV: begin
        if (done) state_d = COMMIT;
      end
      COMMIT: begin
        digits_d  = bcd;
        buf_dec_d = 1'b1;
        buf_blz_d = lat_blz_q;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the current index so seg_en and seg_out move together.
  always_comb begin
    pre_d = pre_q + 1'b1;
    idx_d = idx_q;
    if (pre_q == PRE_LAST) begin
      pre_d = '0;
      idx_d = idx_q + 1'b1;
    end
    above     = digits_q >> {idx_q, 2'b00};
    blank     = (!buf_dec_q && (idx_q >= IDX_W'(HEX_DIGITS))) ||
                (buf_blz_q && (idx_q != '0) && (above == '0));
    seg_out_d = blank ? SEG_BLANK : seg_encode(digits_q[idx_q]);
    seg_en_d  = ~(NUM_DIGITS'(1) << idx_q);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      lat_blz_q <= 1'b0;
      digits_q  <= '0;
      buf_dec_q <= 1'b0;
      buf_blz_q <= 1'b0;
      pre_q     <= '0;
      idx_q     <= '0;
      seg_en_q  <= '1;
      seg_out_q <= SEG_BLANK;
    end else begin
      state_q   <= state_d;
      lat_blz_q <= lat_blz_d;
      digits_q  <= digits_d;
      buf_dec_q <= buf_dec_d;
      buf_blz_q <= buf_blz_d;
      pre_q     <= pre_d;
      idx_q     <= idx_d;
      seg_en_q  <= seg_en_d;
      seg_out_q <= seg_out_d;
    end
  end

  assign bus.busy      = (state_q != IDLE);
  assign bus.seg_en    = seg_en_q;
  assign bus.seg_out   = seg_out_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: table vectors, hand-written corner sequences and random loads
// checked against an arithmetic model of what the eight digits should show.
module tb_seg_scan_ctrl;
  import seg_pkg::*;

  localparam int CLK_HZ     = 800;
  localparam int REFRESH_HZ = 10;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  seg_scan_ctrl_if bus ();

  seg_scan_ctrl #(
    .CLK_HZ     (CLK_HZ),
    .REFRESH_HZ (REFRESH_HZ)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_tests = 0;
  int n_fail  = 0;
  logic [63:0] exp_q[$];

  logic [7:0] enc_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  typedef struct {
    logic [23:0] value;
    bit          dec;
    bit          blz;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Display as {digit7,...,digit0} segment bytes, derived from decimal/hex arithmetic.
  function automatic logic [63:0] model_disp(input logic [23:0] v, input bit dec, input bit blz);
    int dig [8];
    int x = int'(v);
    int msd = 0;
    logic [63:0] r;
    for (int i = 0; i < 8; i++) begin
      if (dec) begin
        dig[i] = x % 10;
        x      = x / 10;
      end else begin
        dig[i] = (i < 6) ? ((int'(v) >> (4*i)) & 15) : 0;
      end
      if (dig[i] != 0) msd = i;
    end
    for (int i = 0; i < 8; i++) begin
      if ((!dec && i >= 6) || (blz && i > msd)) r[8*i +: 8] = 8'hFF;
      else r[8*i +: 8] = enc_tab[dig[i]];
    end
    return r;
  endfunction

  // driver tasks
  task automatic drive_load(input logic [23:0] v, input bit dec, input bit blz);
    @(negedge clk);
    bus.load     = 1'b1;
    bus.value    = v;
    bus.dec_mode = dec;
    bus.blank_lz = blz;
    @(negedge clk);
    bus.load     = 1'b0;
  endtask

  task automatic wait_idle(output int bc);
    bc = 0;
    while (bus.busy && bc < 100) begin
      bc++;
      @(negedge clk);
    end
    check("idle_reached", {63'd0, bus.busy}, 64'd0);
  endtask

  task automatic read_disp(output logic [63:0] d);
    logic [7:0] got;
    logic [7:0] m;
    int cyc;
    got = 8'h00;
    cyc = 0;
    d   = '1;
    repeat (2) @(negedge clk);
    while (got != 8'hFF && cyc < 200) begin
      @(negedge clk);
      cyc++;
      for (int i = 0; i < 8; i++) begin
        m = 8'h01 << i;
        if (bus.seg_en == ~m) begin
          d[8*i +: 8] = bus.seg_out;
          got[i]      = 1'b1;
        end
      end
    end
    check("scan_complete", {56'd0, got}, 64'hFF);
  endtask

  task automatic run_vec(input string name, input logic [23:0] v, input bit dec, input bit blz,
                         input logic [63:0] exp);
    logic [63:0] d;
    int bc;
    exp_q.push_back(exp);
    drive_load(v, dec, blz);
    if (dec) begin
      check({name, "_state"}, 64'(bus.dbg_state), 64'(CONV));
      wait_idle(bc);
      check({name, "_busy_len"}, 64'(bc), 64'd25);
    end else begin
      check({name, "_busy"}, {63'd0, bus.busy}, 64'd0);
      @(negedge clk);
      check({name, "_busy2"}, {63'd0, bus.busy}, 64'd0);
    end
    read_disp(d);
    check(name, d, exp_q.pop_front());
  endtask

  initial begin
    logic [7:0]  prev;
    logic [7:0]  m;
    logic [63:0] d;
    logic [23:0] rv;
    bit          rdec, rblz;
    int          cyc;
    int          bc;

    bus.load     = 1'b0;
    bus.value    = '0;
    bus.dec_mode = 1'b0;
    bus.blank_lz = 1'b0;

    vecs[0] = '{24'hABCDEF, 1'b0, 1'b0, 64'hFFFF_8883_C6A1_868E};
    vecs[1] = '{24'd16777215, 1'b1, 1'b0, 64'hF982_F8F8_F8A4_F992};
    vecs[2] = '{24'd0, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFC0};
    vecs[3] = '{24'd1000, 1'b1, 1'b1, 64'hFFFF_FFFF_F9C0_C0C0};
    vecs[4] = '{24'h000012, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_F9A4};
    vecs[5] = '{24'd123, 1'b1, 1'b0, 64'hC0C0_C0C0_C0F9_A4B0};

    // reset and scan timing
    repeat (3) @(negedge clk);
    check("rst_seg_en", {56'd0, bus.seg_en}, 64'hFF);
    check("rst_seg_out", {56'd0, bus.seg_out}, 64'hFF);
    check("rst_busy", {63'd0, bus.busy}, 64'd0);
    check("rst_state", 64'(bus.dbg_state), 64'(IDLE));
    rst_n = 1'b1;
    @(negedge clk);
    check("first_seg_en", {56'd0, bus.seg_en}, 64'hFE);
    check("first_seg_out", {56'd0, bus.seg_out}, 64'hC0);
    prev = bus.seg_en;
    for (int k = 1; k <= 8; k++) begin
      cyc = 0;
      do begin
        @(negedge clk);
        cyc++;
      end while (bus.seg_en == prev && cyc < 30);
      check($sformatf("scan_period%0d", k), 64'(cyc), 64'd10);
      m = 8'h01 << (k % 8);
      check($sformatf("scan_digit%0d", k), {56'd0, bus.seg_en}, {56'd0, ~m});
      prev = bus.seg_en;
    end
    read_disp(d);
    check("reset_display", d, model_disp(24'd0, 1'b0, 1'b0));

    // table-driven vectors
    for (int i = 0; i < 6; i++) begin
      run_vec($sformatf("vec%0d", i), vecs[i].value, vecs[i].dec, vecs[i].blz, vecs[i].exp);
    end

    // load issued mid-conversion is dropped
    exp_q.push_back(model_disp(24'd123, 1'b1, 1'b0));
    drive_load(24'd123, 1'b1, 1'b0);
    repeat (8) @(negedge clk);
    drive_load(24'd5, 1'b1, 1'b1);
    check("midload_busy", {63'd0, bus.busy}, 64'd1);
    wait_idle(bc);
    read_disp(d);
    check("midload_display", d, exp_q.pop_front());

    // load coinciding with COMMIT is dropped
    exp_q.push_back(model_disp(24'd16777215, 1'b1, 1'b0));
    drive_load(24'd16777215, 1'b1, 1'b0);
    repeat (24) @(negedge clk);
    check("commit_state", 64'(bus.dbg_state), 64'(COMMIT));
    check("commit_busy", {63'd0, bus.busy}, 64'd1);
    bus.load     = 1'b1;
    bus.value    = 24'd5;
    bus.dec_mode = 1'b1;
    bus.blank_lz = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
    check("commit_drop_busy", {63'd0, bus.busy}, 64'd0);
    repeat (3) @(negedge clk);
    check("commit_drop_idle", {63'd0, bus.busy}, 64'd0);
    read_disp(d);
    check("commit_drop_display", d, exp_q.pop_front());

    // reset in the middle of a conversion
    drive_load(24'd999999, 1'b1, 1'b1);
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_busy", {63'd0, bus.busy}, 64'd0);
    check("abort_seg_en", {56'd0, bus.seg_en}, 64'hFF);
    check("abort_seg_out", {56'd0, bus.seg_out}, 64'hFF);
    rst_n = 1'b1;
    cyc = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.busy) cyc++;
    end
    check("abort_no_commit", 64'(cyc), 64'd0);
    read_disp(d);
    check("abort_display", d, model_disp(24'd0, 1'b0, 1'b0));

    // random loads against the model
    for (int n = 0; n < 20; n++) begin
      rv   = 24'($urandom_range(0, 16777215));
      if ($urandom_range(0, 3) == 0) rv = 24'($urandom_range(0, 999));
      rdec = 1'($urandom_range(0, 1));
      rblz = 1'($urandom_range(0, 1));
      run_vec($sformatf("rand%0d", n), rv, rdec, rblz, model_disp(rv, rdec, rblz));
    end

    // final report
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
